// File: rtl/run_length_detector.sv
// run_length_detector: flags runs of >= RUN_LEN identical bits on a serial line, polarity-filtered by MODE.
// Ports: CLK/RST (sync, active-high) | EN sample qualifier | W serial bit | MODE polarity filter
//        (00 ones, 01 zeros, 1x either) | S run-detected level | S_TYPE run polarity |
//        HIT one-cycle pulse when a matching run reaches RUN_LEN | RUN_CNT saturating run length.
// Optional RLD_MAXRUN_EN adds MAX_RUN/MAX_TYPE: longest run since reset and its polarity.
module run_length_detector #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             W,
    input  logic [1:0]       MODE,
    output logic             S,
    output logic             S_TYPE,
    output logic             HIT,
    output logic [CNT_W-1:0] RUN_CNT
`ifdef RLD_MAXRUN_EN
    ,
    output logic [CNT_W-1:0] MAX_RUN,
    output logic             MAX_TYPE
`endif
);
    localparam logic [1:0] IDLE = 2'd0, RUN1 = 2'd1, RUN0 = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TRIG = CNT_W'(RUN_LEN);
    logic [1:0]       state;
    logic [CNT_W-1:0] cntNext;
    logic             sameRun, match;
    always_comb begin
        sameRun = (state == RUN1 && W) || (state == RUN0 && !W);
        cntNext = !sameRun ? CNT_W'(1) : (RUN_CNT == CNT_MAX ? RUN_CNT : RUN_CNT + CNT_W'(1));
        // post-update state always has polarity W, so match is judged on W directly
        match   = MODE[1] || (MODE == 2'b00 && W) || (MODE == 2'b01 && !W);
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            RUN_CNT <= '0;
            S       <= 1'b0;
            S_TYPE  <= 1'b0;
            HIT     <= 1'b0;
`ifdef RLD_MAXRUN_EN
            MAX_RUN  <= '0;
            MAX_TYPE <= 1'b0;
`endif
        end else begin
            HIT <= 1'b0;
            if (EN) begin
                state   <= W ? RUN1 : RUN0;
                RUN_CNT <= cntNext;
                S_TYPE  <= W;
                S       <= match && cntNext >= TRIG;
                // RUN_CNT != TRIG blocks a refire when saturation holds the count at RUN_LEN
                HIT     <= match && cntNext == TRIG && RUN_CNT != TRIG;
`ifdef RLD_MAXRUN_EN
                if (cntNext > MAX_RUN) begin
                    MAX_RUN  <= cntNext;
                    MAX_TYPE <= W;
                end
`endif
            end
        end
    end
endmodule
